nibbler_core_p: RTL and testbench

- Parametrised successor of the 4-bit Nibbler microprocessor core.
- Executes the same 16-opcode accumulator ISA with generic data width, N input ports and N output registers.
- Adds a wait-state handshake to the data RAM.
- Program ROM and data RAM are external. The core sits between the pushbutton/LED top level and the memories.

---
 rtl/nibbler_core_p.sv | 104 ++++++++++
 tb/tb_nibbler_core_p.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/nibbler_core_p.sv
// nibbler_core_p: parametrised accumulator core with fetch/execute phases and a wait-state RAM handshake
module nibbler_core_p #(
  parameter int DATA_W = 4,
  parameter int N_IN = 1,
  parameter int N_OUT = 1,
  localparam int PW = 4 + DATA_W,
  localparam int ADDR_W = DATA_W + PW
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [PW-1:0]             program_byte,
  output logic [ADDR_W-1:0]         PC,
  input  logic [DATA_W-1:0]         mem_rdata,
  input  logic                      mem_ready,
  output logic                      mem_req,
  output logic                      mem_we,
  output logic [ADDR_W-1:0]         address_RAM,
  output logic [DATA_W-1:0]         mem_wdata,
  input  logic [N_IN*DATA_W-1:0]    in_bus,
  output logic [N_OUT*DATA_W-1:0]   out_bus,
  output logic                      phase,
  output logic                      c_flag,
  output logic                      z_flag,
  output logic [3:0]                instr,
  output logic [DATA_W-1:0]         oprnd,
  output logic [DATA_W-1:0]         accu
);
  typedef enum logic [1:0] {FETCH, EXEC, WAIT} state_t;
  state_t state, state_nx;
  logic [ADDR_W-1:0] eff, addr_q;
  logic is_mem, is_jmp, taken, done;
  logic [DATA_W-1:0] x, in_sel, nor_r;
  logic [DATA_W:0] sum, dif;
  logic [N_OUT-1:0][DATA_W-1:0] out_reg;
  assign out_bus = out_reg;
  assign mem_wdata = accu;
  assign phase = state != FETCH;
  // Decode, RAM handshake and next state; the RAM address is live from the second word during EXEC
  always_comb begin
    is_mem = instr inside {4'h3, 4'h6, 4'h7, 4'hB, 4'hF};
    is_jmp = instr inside {4'h0, 4'h1, 4'h8, 4'h9, 4'hC};
    eff = {oprnd, program_byte};
    taken = instr == 4'h0 ? c_flag : instr == 4'h1 ? !c_flag : instr == 4'h8 ? z_flag :
            instr == 4'h9 ? !z_flag : 1'b1;
    mem_req = state == WAIT || (state == EXEC && is_mem);
    mem_we = mem_req && instr == 4'h7;
    address_RAM = (state == EXEC && is_mem) ? eff : addr_q;
    done = (state == EXEC && !is_mem) || (mem_req && mem_ready);
    state_nx = state == FETCH ? EXEC : (mem_req && !mem_ready) ? WAIT : FETCH;
  end
  // ALU operand and results, plus input port selection with out-of-range ports reading zero
  always_comb begin
    x = is_mem ? mem_rdata : oprnd;
    sum = {1'b0, accu} + {1'b0, x};
    dif = {1'b0, accu} + {1'b0, ~x} + (DATA_W+1)'(1);
    nor_r = ~(accu | x);
    in_sel = '0;
    for (int k = 0; k < N_IN; k++) in_sel = 32'(oprnd) == k ? in_bus[k*DATA_W +: DATA_W] : in_sel;
  end
  // State register, program counter, RAM address hold and instruction completion
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      state <= FETCH;
      PC <= '0;
      accu <= '0;
      c_flag <= 1'b0;
      z_flag <= 1'b0;
      instr <= '0;
      oprnd <= '0;
      addr_q <= '0;
      out_reg <= '0;
    end else begin
      state <= state_nx;
      if (state == FETCH) begin
        instr <= program_byte[PW-1:DATA_W];
        oprnd <= program_byte[DATA_W-1:0];
        PC <= PC + ADDR_W'(1);
      end
      if (state == EXEC && (is_mem || is_jmp)) begin
        PC <= (is_jmp && taken) ? eff : PC + ADDR_W'(1);
        addr_q <= is_mem ? eff : addr_q;
      end
      if (done)
        case (instr)
          4'h2, 4'h3: begin
            c_flag <= dif[DATA_W];
            z_flag <= dif[DATA_W-1:0] == '0;
          end
          4'h4: accu <= oprnd;
          4'h5: accu <= in_sel;
          4'h6: accu <= mem_rdata;
          4'hA, 4'hB: begin
            {c_flag, accu} <= sum;
            z_flag <= sum[DATA_W-1:0] == '0;
          end
          4'hD: for (int k = 0; k < N_OUT; k++) if (32'(oprnd) == k) out_reg[k] <= accu;
          4'hE, 4'hF: begin
            accu <= nor_r;
            z_flag <= nor_r == '0;
          end
          default: ;
        endcase
    end
endmodule

// File: tb/tb_nibbler_core_p.sv
// tb_nibbler_core_p: vector table, directed multi-cycle sequences and a random program run against an ISA-level model
module tb_nibbler_core_p;
  localparam int DW = 4, PW = 8, AW = 12;
  logic clock = 0, reset = 1, reset8 = 1;
  always #5 clock = ~clock;

  logic [PW-1:0] program_byte;
  logic [AW-1:0] PC, address_RAM;
  logic [DW-1:0] mem_rdata, mem_wdata, oprnd, accu;
  logic mem_ready = 1, mem_req, mem_we, phase, c_flag, z_flag;
  logic [2*DW-1:0] in_bus = '0, out_bus;
  logic [3:0] instr;
  logic [PW-1:0] rom [4096];
  logic [DW-1:0] dram [4096];
  assign program_byte = rom[PC];
  assign mem_rdata = dram[address_RAM];
  always @(posedge clock) if (mem_req && mem_we && mem_ready) dram[address_RAM] <= mem_wdata;

  nibbler_core_p #(.DATA_W(4), .N_IN(2), .N_OUT(2)) dut (
    .clock(clock), .reset(reset), .program_byte(program_byte), .PC(PC),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we),
    .address_RAM(address_RAM), .mem_wdata(mem_wdata), .in_bus(in_bus), .out_bus(out_bus),
    .phase(phase), .c_flag(c_flag), .z_flag(z_flag), .instr(instr), .oprnd(oprnd), .accu(accu));

  logic [11:0] pb8, rom8 [16];
  logic [19:0] pc8, addr8;
  logic [7:0] wdata8, oprnd8, accu8;
  logic [15:0] in8 = 16'hA53C, out8;
  logic req8, we8, phase8, c8, z8;
  logic [3:0] instr8;
  assign pb8 = rom8[pc8[3:0]];

  nibbler_core_p #(.DATA_W(8), .N_IN(2), .N_OUT(2)) dut8 (
    .clock(clock), .reset(reset8), .program_byte(pb8), .PC(pc8),
    .mem_rdata(8'h00), .mem_ready(1'b1), .mem_req(req8), .mem_we(we8),
    .address_RAM(addr8), .mem_wdata(wdata8), .in_bus(in8), .out_bus(out8),
    .phase(phase8), .c_flag(c8), .z_flag(z8), .instr(instr8), .oprnd(oprnd8), .accu(accu8));

  int total = 0, bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    @(negedge clock);
  endtask

  task automatic do_reset();
    mem_ready = 1;
    reset = 0;
    @(negedge clock);
    @(negedge clock);
    reset = 1;
  endtask

  task automatic clr_rom();
    foreach (rom[i]) rom[i] = '0;
  endtask

  logic [AW-1:0] m_pc;
  logic [DW-1:0] m_acc, m_out [2];
  logic m_c, m_z;
  logic [DW-1:0] mram [4096];

  // one whole instruction at a time, straight from the ISA rules
  task automatic model_step();
    logic [3:0] op, d, x;
    logic [AW-1:0] a;
    int s;
    op = rom[m_pc][7:4];
    d = rom[m_pc][3:0];
    m_pc++;
    a = {d, rom[m_pc]};
    if (op inside {4'h0, 4'h1, 4'h3, 4'h6, 4'h7, 4'h8, 4'h9, 4'hB, 4'hC, 4'hF}) m_pc++;
    x = (op inside {4'h3, 4'h6, 4'h7, 4'hB, 4'hF}) ? mram[a] : d;
    case (op)
      4'h0: if (m_c) m_pc = a;
      4'h1: if (!m_c) m_pc = a;
      4'h8: if (m_z) m_pc = a;
      4'h9: if (!m_z) m_pc = a;
      4'hC: m_pc = a;
      4'h2, 4'h3: begin m_c = m_acc >= x; m_z = m_acc == x; end
      4'h4: m_acc = d;
      4'h5: m_acc = d < 2 ? in_bus[int'(d)*4 +: 4] : 4'h0;
      4'h6: m_acc = x;
      4'h7: mram[a] = m_acc;
      4'hA, 4'hB: begin s = int'(m_acc) + int'(x); m_c = s > 15; m_acc = 4'(s); m_z = m_acc == 0; end
      4'hD: if (d < 2) m_out[d[0]] = m_acc;
      default: begin m_acc = ~(m_acc | x); m_z = m_acc == 0; end
    endcase
  endtask

  typedef struct { logic [3:0] a, p, op, x, acc; logic c, z; } vec_t;
  vec_t vt [10];

  initial begin
    int passes, reqcnt, errs, early, cyc, n;
    vt[0] = '{4'hF, 4'h0, 4'hA, 4'h1, 4'h0, 1'b1, 1'b1};
    vt[1] = '{4'h3, 4'h5, 4'hA, 4'h4, 4'h7, 1'b0, 1'b0};
    vt[2] = '{4'h5, 4'h5, 4'h2, 4'h5, 4'h5, 1'b1, 1'b1};
    vt[3] = '{4'h4, 4'h5, 4'h2, 4'h9, 4'h4, 1'b0, 1'b0};
    vt[4] = '{4'h9, 4'h0, 4'h2, 4'h0, 4'h9, 1'b1, 1'b0};
    vt[5] = '{4'h5, 4'h0, 4'hE, 4'hA, 4'h0, 1'b1, 1'b1};
    vt[6] = '{4'h1, 4'h5, 4'hE, 4'h2, 4'hC, 1'b0, 1'b0};
    vt[7] = '{4'h7, 4'h7, 4'h4, 4'h2, 4'h2, 1'b1, 1'b1};
    vt[8] = '{4'h0, 4'h0, 4'hE, 4'h0, 4'hF, 1'b1, 1'b0};
    vt[9] = '{4'h8, 4'h8, 4'hA, 4'h7, 4'hF, 1'b0, 1'b0};
    clr_rom();
    foreach (dram[i]) dram[i] = '0;
    foreach (rom8[i]) rom8[i] = 12'h400;
    #1 reset = 0;
    reset8 = 0;
    #1 chk("reset", {PC, accu, c_flag, z_flag, instr, oprnd, out_bus, address_RAM, phase, mem_req, mem_we}, '0);
    @(negedge clock);

    for (int i = 0; i < 10; i++) begin
      clr_rom();
      rom[0] = {4'h4, vt[i].a};
      rom[1] = {4'h2, vt[i].p};
      rom[2] = {4'h4, vt[i].a};
      rom[3] = {vt[i].op, vt[i].x};
      do_reset();
      tick(8);
      chk($sformatf("alu%0d", i), {accu, c_flag, z_flag}, {vt[i].acc, vt[i].c, vt[i].z});
    end

    clr_rom();
    rom[0] = 8'h46; rom[1] = 8'hD0;
    do_reset();
    tick(4);
    chk("out0", out_bus, 8'h06);
    chk("out0_pc", PC, 12'd2);
    chk("out0_flags", {c_flag, z_flag}, 2'b00);

    clr_rom();
    rom[0] = 8'h4F; rom[1] = 8'hA1; rom[2] = 8'h00; rom[3] = 8'h05;
    do_reset();
    tick(4);
    chk("add_carry", {accu, c_flag, z_flag}, {4'h0, 1'b1, 1'b1});
    tick(2);
    chk("jc_taken", {phase, PC}, {1'b0, 12'h005});

    clr_rom();
    rom[0] = 8'h43; rom[1] = 8'hAF; rom[2] = 8'h90; rom[3] = 8'h01;
    do_reset();
    passes = 0;
    cyc = 0;
    while (!(!phase && PC == 12'd4) && cyc < 60) begin
      if (phase && instr == 4'hA) passes++;
      tick(1);
      cyc++;
    end
    chk("loop_bound", cyc < 60, 1);
    chk("loop_passes", passes, 3);
    chk("loop_exit", {PC, accu, z_flag}, {12'd4, 4'h0, 1'b1});

    clr_rom();
    rom[0] = 8'h20; rom[1] = 8'h61; rom[2] = 8'h23;
    dram[12'h123] = 4'h9;
    do_reset();
    mem_ready = 0;
    tick(2);
    reqcnt = 0; errs = 0; early = 0; cyc = 0;
    while (cyc < 20) begin
      if (mem_req) begin
        reqcnt++;
        if (address_RAM != 12'h123 || mem_we) errs++;
        if (accu != 4'h0) early++;
        mem_ready = reqcnt >= 4;
      end else if (reqcnt > 0) break;
      tick(1);
      cyc++;
    end
    mem_ready = 1;
    chk("ld_req_cycles", reqcnt, 4);
    chk("ld_addr_hold", errs, 0);
    chk("ld_early_accu", early, 0);
    chk("ld_result", {accu, c_flag, z_flag}, {4'h9, 1'b1, 1'b1});

    clr_rom();
    rom[0] = 8'h4A; rom[1] = 8'h70; rom[2] = 8'hF0;
    dram[12'h0F0] = 4'h0;
    do_reset();
    mem_ready = 0;
    tick(4);
    chk("st_wait", {mem_req, mem_we, address_RAM}, {1'b1, 1'b1, 12'h0F0});
    #2 reset = 0;
    #1 chk("st_abort", {mem_req, phase, PC, accu}, '0);
    @(negedge clock);
    reset = 1;
    mem_ready = 1;
    chk("st_nowrite", dram[12'h0F0], 4'h0);
    chk("restart_pc", {phase, PC}, '0);
    tick(1);
    chk("restart_fetch", {PC, instr, oprnd}, {12'd1, 4'h4, 4'hA});

    rom8[0] = 12'h501; rom8[1] = 12'hD01; rom8[2] = 12'h502; rom8[3] = 12'hD05;
    reset8 = 1;
    tick(4);
    chk("port_in1_out1", out8, 16'hA500);
    tick(2);
    chk("port_in2_zero", accu8, 8'h00);
    tick(2);
    chk("port_out5_nop", out8, 16'hA500);

    foreach (rom[i]) rom[i] = 8'($urandom);
    foreach (dram[i]) begin dram[i] = 4'($urandom); mram[i] = dram[i]; end
    in_bus = 8'($urandom);
    m_pc = '0; m_acc = '0; m_c = 0; m_z = 0; m_out[0] = '0; m_out[1] = '0;
    do_reset();
    n = 0;
    cyc = 0;
    while (n < 300 && cyc < 6000) begin
      mem_ready = $urandom_range(0, 2) != 0;
      if (!phase) begin
        chk("rand_state", {PC, accu, c_flag, z_flag, out_bus}, {m_pc, m_acc, m_c, m_z, m_out[1], m_out[0]});
        model_step();
        n++;
      end
      tick(1);
      cyc++;
    end
    chk("rand_steps", n, 300);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
